// File: rtl/pipe_rr_arbiter_with_tag.sv
// pipe_rr_arbiter_with_tag
// Lets N_REQ requesters share one fixed-latency, valid-only arithmetic pipe.
//
// Each cycle a round-robin arbiter picks one request and registers it into the pipe.
// A tag shift register runs in step with the pipe and carries the requester id, so
// every result goes back to the requester that issued it.
//
// If the pipe's output valid and the tag tail valid ever disagree, the result is
// dropped and a sticky error flag is raised.
module pipe_rr_arbiter_with_tag #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_gnt,
  output logic                     pipe_in_vld,
  output logic [WIDTH-1:0]         pipe_in_data,
  input  logic                     pipe_out_vld,
  input  logic [WIDTH-1:0]         pipe_out_data,
  output logic [N_REQ-1:0]         res_vld,
  output logic [WIDTH-1:0]         res_data,
  output logic                     err
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] rr_next;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] pipe_in_id;

  logic            tag_vld [LATENCY];
  logic [ID_W-1:0] tag_id  [LATENCY];
  logic            tail_vld;
  logic [ID_W-1:0] tail_id;

  // Round-robin grant: take the first valid requester, starting at rr_ptr and wrapping.
  always_comb begin
    // NOTE: every output of this block gets a default before the loop. Otherwise a
    // path that skips an assignment would infer a latch.
    req_gnt  = '0;
    gnt_id   = '0;
    gnt_any  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    if (!rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        // rr_ptr + k is below 2*N_REQ, so a single conditional subtract wraps it
        // even when N_REQ is not a power of two.
        scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
        if (scan_sum >= (ID_W+1)'(N_REQ)) begin
          scan_sum = scan_sum - (ID_W+1)'(N_REQ);
        end
        scan_idx = scan_sum[ID_W-1:0];
        if (!gnt_any && req_vld[scan_idx]) begin
          gnt_any           = 1'b1;
          gnt_id            = scan_idx;
          req_gnt[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign rr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

  // Issue stage: register the granted request into the pipe and advance the pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every register then
    // updates from values sampled at the same clock edge.
    if (rst) begin
      rr_ptr       <= '0;
      pipe_in_vld  <= 1'b0;
      pipe_in_data <= '0;
      pipe_in_id   <= '0;
    end else begin
      pipe_in_vld <= gnt_any;
      if (gnt_any) begin
        rr_ptr       <= rr_next;
        pipe_in_data <= req_data[int'(gnt_id)*WIDTH +: WIDTH];
        pipe_in_id   <= gnt_id;
      end
    end
  end

  // Tag pipe: a LATENCY-deep {vld,id} shifter fed from the issue stage, so its tail
  // lines up with pipe_out_vld.
  always_ff @(posedge clk) begin
    // NOTE: the tag array is reset even though it behaves like storage. A stale tag
    // valid left over from before reset would raise a false err.
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
      end
    end else begin
      tag_vld[0] <= pipe_in_vld;
      tag_id[0]  <= pipe_in_id;
      for (int s = 1; s < LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign tail_vld = tag_vld[LATENCY-1];
  assign tail_id  = tag_id[LATENCY-1];

  // Return stage: route a matched result to its issuer, and flag any valid mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld  <= '0;
      res_data <= '0;
      err      <= 1'b0;
    end else begin
      res_vld <= '0;
      if (pipe_out_vld && tail_vld) begin
        res_vld  <= {{(N_REQ-1){1'b0}}, 1'b1} << tail_id;
        res_data <= pipe_out_data;
      end
      if (pipe_out_vld != tail_vld) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_rr_arbiter_with_tag.sv
// tb_pipe_rr_arbiter_with_tag
// Wraps the arbiter around a model of the shared pipe: LATENCY stages computing
// 3*x+7. An inject input lets the bench force a stray pipe_out_vld.
//
// A cycle-indexed behavioural model predicts grants, pipe issues, results and err.
// One negedge process compares the DUT against that model every cycle. Directed
// scenarios add literal expectations, then randomized traffic follows.
module tb_pipe_rr_arbiter_with_tag;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_gnt;
  logic           pipe_in_vld;
  logic [W-1:0]   pipe_in_data;
  logic           pipe_out_vld;
  logic [W-1:0]   pipe_out_data;
  logic [N-1:0]   res_vld;
  logic [W-1:0]   res_data;
  logic           err;
  logic           inject;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_rr_arbiter_with_tag #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_gnt      (req_gnt),
    .pipe_in_vld  (pipe_in_vld),
    .pipe_in_data (pipe_in_data),
    .pipe_out_vld (pipe_out_vld),
    .pipe_out_data(pipe_out_data),
    .res_vld      (res_vld),
    .res_data     (res_data),
    .err          (err)
  );

  function automatic logic [W-1:0] pipe_fn(input logic [W-1:0] x);
    logic [15:0] t;
    t = {8'd0, x} * 16'd3 + 16'd7;
    return t[W-1:0];
  endfunction

  // Shared pipe model, reset by the same rst as the arbiter.
  logic         pv [L];
  logic [W-1:0] pd [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= pipe_in_vld;
      pd[0] <= pipe_fn(pipe_in_data);
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign pipe_out_vld  = pv[L-1] | inject;
  assign pipe_out_data = pd[L-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_cyc = 0;
  int           m_rr  = 0;
  bit           m_armed = 0;
  bit           m_err   = 0;
  logic [W-1:0] m_res_data = '0;
  logic [N-1:0] m_res_vld_at [int];
  logic [W-1:0] m_res_dat_at [int];
  logic [W-1:0] m_pin_at     [int];
  bit           m_arrive_at  [int];

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Single compare process: check outputs, then advance the model across the next edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_rv;
    logic [N-1:0] exp_g;
    int           g;
    if (m_armed) begin
      exp_rv = m_res_vld_at.exists(m_cyc) ? m_res_vld_at[m_cyc] : '0;
      if (m_res_vld_at.exists(m_cyc)) m_res_data = m_res_dat_at[m_cyc];
      check("res_vld", res_vld, exp_rv);
      check("res_data", res_data, m_res_data);
      check("err", err, m_err);
      check("pipe_in_vld", pipe_in_vld, m_pin_at.exists(m_cyc));
      if (m_pin_at.exists(m_cyc)) check("pipe_in_data", pipe_in_data, m_pin_at[m_cyc]);
    end
    g     = rst ? -1 : model_grant(req_vld, m_rr);
    exp_g = (g < 0) ? '0 : N'(1) << g;
    if (m_armed || rst) check("req_gnt", req_gnt, exp_g);
    if (rst) begin
      m_res_vld_at.delete();
      m_res_dat_at.delete();
      m_pin_at.delete();
      m_arrive_at.delete();
      m_rr       = 0;
      m_err      = 0;
      m_res_data = '0;
      m_armed    = 1;
    end else begin
      if (inject && !m_arrive_at.exists(m_cyc)) m_err = 1;
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        m_pin_at[m_cyc + 1]         = req_data[g*W +: W];
        m_arrive_at[m_cyc + 1 + L]  = 1;
        m_res_vld_at[m_cyc + 2 + L] = N'(1) << g;
        m_res_dat_at[m_cyc + 2 + L] = pipe_fn(req_data[g*W +: W]);
      end
    end
    m_res_vld_at.delete(m_cyc);
    m_res_dat_at.delete(m_cyc);
    m_pin_at.delete(m_cyc);
    m_arrive_at.delete(m_cyc);
    m_cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [N-1:0] gnt_log [8];
  logic [N-1:0] exp_seq [8];

  initial begin
    rst      = 1'b1;
    req_vld  = '1;
    req_data = '0;
    inject   = 1'b0;

    // Test 1: reset held three cycles with every requester asking.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_gnt_in_rst", req_gnt, 4'b0000);
    end
    check("t1_pipe_in_vld", pipe_in_vld, 1'b0);
    check("t1_pipe_in_data", pipe_in_data, 8'h00);
    check("t1_res_vld", res_vld, 4'b0000);
    check("t1_res_data", res_data, 8'h00);
    check("t1_err", err, 1'b0);
    req_vld = '0;
    rst     = 1'b0;

    // Test 2: single request on 2; the result appears L+2 cycles after the grant.
    tick();
    req_vld = 4'b0100;
    req_data[2*W +: W] = 8'h19;
    settle();
    check("t2_gnt", req_gnt, 4'b0100);
    tick();
    req_vld = '0;
    check("t2_pipe_in_vld", pipe_in_vld, 1'b1);
    check("t2_pipe_in_data", pipe_in_data, 8'h19);
    for (int i = 0; i < L; i++) tick();
    check("t2_res_early", res_vld, 4'b0000);
    tick();
    check("t2_res_vld", res_vld, 4'b0100);
    check("t2_res_data", res_data, 8'h52);

    // Test 4: pointer now sits at 3; requests 0 and 1 must wrap to 0 then 1.
    req_vld = 4'b0011;
    req_data[0 +: W] = 8'h21;
    req_data[W +: W] = 8'h42;
    settle();
    check("t4_gnt_wrap0", req_gnt, 4'b0001);
    tick();
    req_vld = 4'b0010;
    settle();
    check("t4_gnt_then1", req_gnt, 4'b0010);
    tick();
    req_vld = '0;
    for (int i = 0; i < L + 4; i++) tick();

    // Test 3: all four requesting for 8 cycles after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      req_vld  = 4'b1111;
      req_data = $urandom;
      settle();
      gnt_log[i] = req_gnt;
      tick();
    end
    req_vld = '0;
    for (int i = 0; i < 8; i++) check("t3_gnt_seq", gnt_log[i], exp_seq[i]);
    for (int i = 0; i < L + 4; i++) tick();

    // Test 5: a stray pipe valid with an empty tag pipe sets a sticky err.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("t5_err_set", err, 1'b1);
    check("t5_res_dropped", res_vld, 4'b0000);
    for (int i = 0; i < 4; i++) tick();
    check("t5_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_err_cleared", err, 1'b0);

    // Test 6: reset with three results in flight drops all of them.
    req_vld  = 4'b1111;
    req_data = 32'h0403_0201;
    for (int i = 0; i < 3; i++) tick();
    req_vld = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < L + 4; i++) begin
      tick();
      check("t6_no_res", res_vld, 4'b0000);
      check("t6_no_err", err, 1'b0);
    end

    // Randomized traffic, with rare resets and rare stray pipe valids.
    for (int i = 0; i < 600; i++) begin
      req_vld  = N'($urandom);
      req_data = $urandom;
      rst      = ($urandom_range(0, 99) == 0);
      inject   = (i > 400) && ($urandom_range(0, 149) == 0);
      tick();
    end
    rst     = 1'b0;
    inject  = 1'b0;
    req_vld = '0;
    for (int i = 0; i < L + 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
